// File: rtl/ddmtd_telemetry_tx_if.sv
// Bus bundle for the DDMTD phase-error telemetry transmitter: the sample strobe
// and enable going in, and the serial line plus status coming out.
interface ddmtd_telemetry_tx_if;
  logic        ena;
  logic        phase_valid;
  logic [15:0] phase_err;
  logic        tx;
  logic        busy;
  logic [7:0]  drop_cnt;

  modport master (output ena, phase_valid, phase_err, input tx, busy, drop_cnt);
  modport slave  (input ena, phase_valid, phase_err, output tx, busy, drop_cnt);
endinterface

// File: rtl/ddmtd_telemetry_tx.sv
// Frames each phase-error sample as A5/seq/err_hi/err_lo/chk and sends it 8N1,
// LSB first, through a one-deep holding register that counts overwritten samples.
module ddmtd_telemetry_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ERR_W        = 16
) (
  input logic            clk,
  input logic            rst_n,
  ddmtd_telemetry_tx_if.slave bus
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  START   = 2'd1;
  localparam logic [1:0]  DATA    = 2'd2;
  localparam logic [1:0]  STOP    = 2'd3;
  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

  logic [1:0]       state_r;
  logic [15:0]      clk_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [2:0]       byte_idx_r;
  logic             tx_r;
  logic             busy_r;
  logic [7:0]       drop_cnt_r;
  logic [7:0]       seq_r;
  logic [ERR_W-1:0] hold_val_r;
  logic             hold_full_r;
  logic [ERR_W-1:0] frame_err_r;

  logic             capture_s;
  logic             unload_s;
  logic             bit_end_s;
  logic [7:0]       cur_byte_s;

  // Check byte: XOR of sync, sequence and both error bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] seq, input logic [15:0] err);
    return 8'hA5 ^ seq ^ err[15:8] ^ err[7:0];
  endfunction

  // Capture/unload qualifiers and end-of-bit detect.
  always_comb begin
    capture_s = bus.phase_valid & bus.ena;
    unload_s  = (state_r == IDLE) & hold_full_r & bus.ena;
    bit_end_s = (clk_cnt_r == CNT_MAX);
  end

  // Byte currently on the wire, selected by the frame byte index.
  always_comb begin
    cur_byte_s = 8'hFF;
    case (byte_idx_r)
      3'd0:    cur_byte_s = 8'hA5;
      3'd1:    cur_byte_s = seq_r;
      3'd2:    cur_byte_s = frame_err_r[15:8];
      3'd3:    cur_byte_s = frame_err_r[7:0];
      3'd4:    cur_byte_s = frame_chk(seq_r, frame_err_r);
      default: cur_byte_s = 8'hFF;
    endcase
  end

  // Holding register; a capture coinciding with an unload is not a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_val_r  <= '0;
      hold_full_r <= 1'b0;
      drop_cnt_r  <= 8'd0;
    end else if (capture_s) begin
      hold_val_r  <= bus.phase_err;
      hold_full_r <= 1'b1;
      if (hold_full_r && !unload_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end else if (unload_s) begin
      hold_full_r <= 1'b0;
    end
  end

  // Serialiser FSM; tx is loaded with the next bit level on each transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      clk_cnt_r   <= 16'd0;
      bit_idx_r   <= 3'd0;
      byte_idx_r  <= 3'd0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      seq_r       <= 8'd0;
      frame_err_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (unload_s) begin
            state_r     <= START;
            frame_err_r <= hold_val_r;
            byte_idx_r  <= 3'd0;
            bit_idx_r   <= 3'd0;
            clk_cnt_r   <= 16'd0;
            tx_r        <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r   <= DATA;
            clk_cnt_r <= 16'd0;
            bit_idx_r <= 3'd0;
            tx_r      <= cur_byte_s[0];
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            clk_cnt_r <= 16'd0;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= cur_byte_s[bit_idx_r + 3'd1];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            clk_cnt_r <= 16'd0;
            if (byte_idx_r == 3'd4) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              seq_r   <= seq_r + 8'd1;
            end else begin
              byte_idx_r <= byte_idx_r + 3'd1;
              state_r    <= START;
              tx_r       <= 1'b0;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx       = tx_r;
  assign bus.busy     = busy_r;
  assign bus.drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_ddmtd_telemetry_tx.sv
// Randomised and directed bench for ddmtd_telemetry_tx: a frame-level reference
// model queues expected frames, a UART receiver pops and compares them.
module tb_ddmtd_telemetry_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ddmtd_telemetry_tx_if bus();

  ddmtd_telemetry_tx #(.CLKS_PER_BIT(CPB), .ERR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state: pending sample, sequence, drops, cycles left in frame.
  logic [39:0] exp_q[$];
  logic        m_pend = 1'b0;
  logic [15:0] m_val = 16'd0;
  logic [7:0]  m_seq = 8'd0;
  logic [7:0]  m_drop = 8'd0;
  int          m_rem = 0;
  logic        m_start;
  logic        m_cap;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame occupies 50*CPB cycles, then one idle cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_pend = 1'b0; m_val = 16'd0; m_seq = 8'd0; m_drop = 8'd0; m_rem = 0;
      end else begin
        m_start = (m_rem == 0) && m_pend && bus.ena;
        m_cap   = bus.phase_valid && bus.ena;
        if (m_rem != 0) m_rem = m_rem - 1;
        if (m_start) begin
          exp_q.push_back({8'hA5, m_seq, m_val[15:8], m_val[7:0],
                           8'hA5 ^ m_seq ^ m_val[15:8] ^ m_val[7:0]});
          m_seq = m_seq + 8'd1;
          m_rem = 50 * CPB;
        end
        if (m_cap) begin
          if (m_pend && !m_start && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
          m_pend = 1'b1;
          m_val  = bus.phase_err;
        end else if (m_start) begin
          m_pend = 1'b0;
        end
      end
    end
  end

  // Monitor: per-cycle status checks plus a mid-bit sampling UART receiver.
  logic        rx_act = 1'b0;
  int          rx_cnt = 0;
  int          nbytes = 0;
  logic [7:0]  rx_byte = 8'd0;
  logic [39:0] rx_frame = 40'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_act = 1'b0;
        nbytes = 0;
      end else begin
        check("busy", 40'(bus.busy), 40'(m_rem != 0));
        check("drop_cnt", 40'(bus.drop_cnt), 40'(m_drop));
        if (m_rem == 0) check("tx_idle", 40'(bus.tx), 40'd1);
        if (rx_act) rx_cnt++;
        else if (bus.tx == 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
        end
        if (rx_act && (rx_cnt % CPB) == CPB / 2) begin
          if (rx_cnt / CPB == 0) begin
            check("start_bit", 40'(bus.tx), 40'd0);
          end else if (rx_cnt / CPB <= 8) begin
            rx_byte[rx_cnt / CPB - 1] = bus.tx;
          end else begin
            check("stop_bit", 40'(bus.tx), 40'd1);
            rx_act   = 1'b0;
            rx_frame = {rx_frame[31:0], rx_byte};
            nbytes++;
            if (nbytes == 5) begin
              nbytes = 0;
              if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL frame: got %0h, expected none", rx_frame);
              end else begin
                check("frame", rx_frame, exp_q.pop_front());
              end
            end
          end
        end
      end
    end
  end

  task automatic strobe(input logic [15:0] v);
    bus.phase_valid = 1'b1;
    bus.phase_err   = v;
    @(negedge clk);
    bus.phase_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input string name);
    int n = 0;
    while (bus.busy !== level && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout_%s: busy stuck at %0b, wanted %0b", name, bus.busy, level);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.ena = 1'b1;
    bus.phase_valid = 1'b0;
    bus.phase_err = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_tx", 40'(bus.tx), 40'd1);
    check("rst_busy", 40'(bus.busy), 40'd0);
    check("rst_drop", 40'(bus.drop_cnt), 40'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single sample: start bit two cycles after the strobe, 200-cycle busy.
    strobe(16'h1234);
    check("lat_n1_tx", 40'(bus.tx), 40'd1);
    @(negedge clk);
    check("lat_n2_tx", 40'(bus.tx), 40'd0);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_len", 40'(cnt), 40'(50 * CPB));
    check("single_drop", 40'(bus.drop_cnt), 40'd0);
    repeat (5) @(negedge clk);

    // Back-to-back: FFFF overwritten by 8000 during the first frame.
    strobe(16'h0001);
    repeat (20) @(negedge clk);
    strobe(16'hFFFF);
    repeat (20) @(negedge clk);
    strobe(16'h8000);
    wait_busy(1'b0, "b2b_a");
    wait_busy(1'b1, "b2b_b");
    wait_busy(1'b0, "b2b_c");
    check("b2b_drop", 40'(bus.drop_cnt), 40'd1);
    repeat (5) @(negedge clk);

    // Capture on the exact unload cycle of the previous sample.
    strobe(16'h5555);
    strobe(16'h00AA);
    check("simul_drop", 40'(bus.drop_cnt), 40'd1);
    wait_busy(1'b0, "sim_a");
    wait_busy(1'b1, "sim_b");
    wait_busy(1'b0, "sim_c");
    repeat (5) @(negedge clk);

    // ena dropped mid byte 2 with a sample pending; held sample goes after re-enable.
    strobe(16'h7777);
    repeat (50) @(negedge clk);
    strobe(16'h4242);
    repeat (50) @(negedge clk);
    bus.ena = 1'b0;
    strobe(16'h9999);
    wait_busy(1'b0, "ena_a");
    repeat (40) @(negedge clk);
    check("ena_no_start", 40'(bus.busy), 40'd0);
    bus.ena = 1'b1;
    wait_busy(1'b1, "ena_b");
    wait_busy(1'b0, "ena_c");
    repeat (5) @(negedge clk);

    // Reset at bit 5 of byte 3; no resume, next frame restarts at seq 0.
    strobe(16'h3C3C);
    repeat (1 + 3 * 10 * CPB + 6 * CPB + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 40'(bus.tx), 40'd1);
    check("rst_mid_busy", 40'(bus.busy), 40'd0);
    check("rst_mid_drop", 40'(bus.drop_cnt), 40'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_resume", 40'(bus.busy), 40'd0);
    strobe(16'h0BAD);
    wait_busy(1'b1, "rst_b");
    wait_busy(1'b0, "rst_c");

    // Random strobes with random enable.
    for (int i = 0; i < 3000; i++) begin
      bus.ena         = ($urandom_range(7, 0) != 0);
      bus.phase_valid = ($urandom_range(15, 0) == 0);
      bus.phase_err   = 16'($urandom);
      @(negedge clk);
    end
    bus.ena = 1'b1;
    bus.phase_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_busy(1'b0, "rand");
      repeat (3) @(negedge clk);
    end

    // Sequence wrap across 257 frames, then drop counter saturation.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      strobe(16'($urandom));
      wait_busy(1'b1, "wrap_b");
      wait_busy(1'b0, "wrap_c");
    end
    for (int i = 0; i < 300; i++) strobe(16'($urandom));
    check("drop_sat", 40'(bus.drop_cnt), 40'd255);
    for (int i = 0; i < 3; i++) begin
      wait_busy(1'b0, "drain");
      repeat (3) @(negedge clk);
    end
    check("all_frames_seen", 40'(exp_q.size()), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
